scan_ctrl: RTL
==============

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter SHOW_CYC, default 1000, clock cycles each digit is driven; SHALL be >= 1.
REQ-002 Parameter BLANK_CYC, default 50, clock cycles of all-off blanking between digits; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  scan enable; 0 SHALL force idle.
REQ-006 freeze  input  1  holds the current digit while in SHOW.
REQ-007 ndig  input  3  number of active digits minus 1 (0 = one digit, 7 = eight digits).
REQ-008 addr  output  3  select index for the downstream 8:1 4-bit data mux (data_38 addr).
REQ-009 dig_n  output  8  active-low one-hot digit enable.
REQ-010 blank  output  1  1 while no digit is driven.
REQ-011 frame_done  output  1  one-cycle pulse when the scan wraps from the last active digit to 0.

Function
REQ-012 FSM states: IDLE, SHOW, BLANK; all outputs SHALL be registered.
REQ-013 IDLE: addr=0, dig_n=8'hFF, blank=1, frame_done=0, cycle counter=0.
REQ-014 IDLE->SHOW on the first clock edge with en=1; addr remains 0.
REQ-015 SHOW: dig_n bit[addr]=0, all other bits 1; blank=0.
REQ-016 SHOW lasts exactly SHOW_CYC cycles (counter 0..SHOW_CYC-1), then SHALL go to BLANK.
REQ-017 On the SHOW->BLANK edge addr SHALL advance: addr+1 if addr < ndig, else 0.
REQ-018 frame_done SHALL be 1 for exactly the one cycle following the edge where addr wraps to 0; it is 0 at all other times.
REQ-019 BLANK: dig_n=8'hFF, blank=1; lasts exactly BLANK_CYC cycles, then SHALL go to SHOW.
REQ-020 Because addr changes only at the start of BLANK, downstream mux data SHALL be stable for the whole following SHOW.
REQ-021 freeze=1 in SHOW SHALL hold the counter and addr and keep the digit lit; counting resumes from the held value when freeze=0. freeze SHALL be ignored in BLANK and IDLE.
REQ-022 en=0 in any state SHALL return the FSM to IDLE on the next edge with the REQ-013 values; no frame_done pulse is generated.
REQ-023 ndig is sampled only at the REQ-017 advance; if ndig is lowered below the current addr, the next advance SHALL wrap to 0 and pulse frame_done.
REQ-024 With ndig=0 addr SHALL stay 0, and frame_done SHALL pulse after every SHOW period.
REQ-025 Counter width SHALL be clog2 of max(SHOW_CYC, BLANK_CYC) and SHALL NOT overflow for any legal parameter value.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE with the REQ-013 values, regardless of en, freeze or current state, including mid-SHOW or mid-BLANK.
REQ-027 After rst_n returns to 1 with en=1, SHOW SHALL begin on the next edge at addr=0.

Structure
REQ-028 State encodings (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2) SHALL reside in a shared include header used by all display-path blocks.
REQ-029 One sub-module, cyc_cnt, SHALL provide the loadable, clearable, holdable cycle counter with a terminal-count flag; the FSM and decode logic SHALL be in scan_ctrl.
REQ-030 The 3-to-8 active-low decode of addr SHALL be registered together with the state so that dig_n is glitch-free.

Verification (SHOW_CYC=4, BLANK_CYC=2)
REQ-031 Reset then en=1, ndig=7: addr sequence 0..7,0; each digit has dig_n low for exactly 4 cycles and 2 blank cycles between digits; frame_done pulses once per 48 cycles.
REQ-032 ndig=2: addr cycles 0,1,2,0; dig_n takes values FE, FD, FB; frame_done period is 18 cycles.
REQ-033 freeze=1 for 10 cycles during the SHOW of addr=3: dig_n holds F7 for 4+10 cycles total; no addr change occurs during the freeze.
REQ-034 At addr=6, change ndig from 7 to 3: the next advance goes to addr=0 and frame_done pulses.
REQ-035 rst_n=0 for one cycle mid-BLANK at addr=5: next cycle shows addr=0, dig_n=FF, blank=1; then SHOW at addr 0 follows.
REQ-036 en dropped during SHOW at addr=4: the next cycle is IDLE (dig_n=FF, addr=0) and frame_done stays 0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared display-path definitions: scan FSM state encodings and small helpers
// used by scan_ctrl and the other blocks that drive the digit bus.
package scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  // Counter only has to reach max-1, so clog2(max) bits suffice; keep >= 1 bit.
  function automatic int cnt_width(input int show_cyc, input int blank_cyc);
    int m;
    m = (show_cyc > blank_cyc) ? show_cyc : blank_cyc;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic logic [7:0] dig_decode(input logic [2:0] a);
    return ~(8'b1 << a);
  endfunction

endpackage

// File: rtl/scan_ctrl_cyc_cnt.sv
// Loadable, clearable, holdable cycle counter with a terminal-count compare.
module cyc_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  input  logic [CNT_W-1:0] tc_val,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (hold) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/scan_ctrl.sv
// Multiplexed 8-digit display scan controller: SHOW/BLANK sequencing over
// ndig+1 digits with registered mux address, digit enables and frame pulse.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int SHOW_CYC  = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       freeze,
  input  logic [2:0] ndig,
  output logic [2:0] addr,
  output logic [7:0] dig_n,
  output logic       blank,
  output logic       frame_done
);

  localparam int CNT_W = cnt_width(SHOW_CYC, BLANK_CYC);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  logic [1:0]       state_d, state_q;
  logic [2:0]       addr_d, addr_q;
  logic [7:0]       dig_n_d, dig_n_q;
  logic             blank_d, blank_q;
  logic             fd_d, fd_q;
  logic             cnt_clr, cnt_hold, cnt_tc;
  logic [CNT_W-1:0] tc_val;
  logic [CNT_W-1:0] cnt;

  cyc_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .hold     (cnt_hold),
    .tc_val   (tc_val),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fd_d     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_hold = 1'b0;
    tc_val   = SHOW_LAST;
    case (state_q)
      ST_SHOW: begin
        if (freeze) begin
          cnt_hold = 1'b1;
        end else if (cnt_tc) begin
          // Address moves only on entry to BLANK so mux data settles unseen.
          state_d = ST_BLANK;
          cnt_clr = 1'b1;
          if (addr_q < ndig) begin
            addr_d = addr_q + 3'd1;
          end else begin
            addr_d = 3'd0;
            fd_d   = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        tc_val = BLANK_LAST;
        if (cnt_tc) begin
          state_d = ST_SHOW;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        addr_d  = 3'd0;
        state_d = en ? ST_SHOW : ST_IDLE;
      end
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      addr_d  = 3'd0;
      fd_d    = 1'b0;
      cnt_clr = 1'b1;
    end
    // Decode from next-state values so dig_n is a clean register output.
    blank_d = (state_d != ST_SHOW);
    dig_n_d = blank_d ? 8'hFF : dig_decode(addr_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 3'd0;
      dig_n_q <= 8'hFF;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dig_n_q <= dig_n_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
    end
  end

  assign addr       = addr_q;
  assign dig_n      = dig_n_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule
